// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: serializes RDI packets and 2- or 4-phase adapter packets
// onto one 64-bit serializer word stream, using round robin when both sources are ready.
module sb_tx_arbiter #(
    parameter logic [4:0] OPC_WITH_DATA = 5'b11011
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rdi_req,
    input  logic [63:0] i_rdi_pkt,
    output logic        o_rdi_ack,
    input  logic [31:0] i_lp_cfg,
    input  logic        i_lp_cfg_vld,
    output logic        o_lp_cfg_crd,
    output logic        o_adp_err,
    output logic        o_ser_valid,
    output logic [63:0] o_ser_data,
    input  logic        i_ser_done,
    output logic        o_busy
);

    typedef enum logic [2:0] {IDLE, SEND_RDI, SEND_HDR, GAP, SEND_DAT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  phase;
    logic [63:0] hdr_buf, dat_buf, rdi_buf;
    logic        adp_pending;
    logic        drop_burst;
    logic        last_adp;
    logic        has_data;
    logic        rdi_req_eff;
    logic        grant_rdi, grant_adp;
    logic        adp_clr;
    logic        rdi_done;

    assign has_data = (hdr_buf[4:0] == OPC_WITH_DATA);
    // The requester still holds i_rdi_req in the cycle the ack is visible.
    assign rdi_req_eff = i_rdi_req && !o_rdi_ack;

    // Adapter capture. An offending burst that starts while a packet is pending
    // is swallowed until vld drops, so it raises a single error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase       <= 2'd0;
            hdr_buf     <= 64'h0;
            dat_buf     <= 64'h0;
            adp_pending <= 1'b0;
            drop_burst  <= 1'b0;
            o_adp_err   <= 1'b0;
        end else begin
            o_adp_err <= 1'b0;
            if (i_lp_cfg_vld) begin
                if (adp_pending || drop_burst) begin
                    if (!drop_burst) o_adp_err <= 1'b1;
                    drop_burst <= 1'b1;
                end else begin
                    case (phase)
                        2'd0: hdr_buf[31:0]  <= i_lp_cfg;
                        2'd1: hdr_buf[63:32] <= i_lp_cfg;
                        2'd2: dat_buf[31:0]  <= i_lp_cfg;
                        2'd3: dat_buf[63:32] <= i_lp_cfg;
                        default: ;
                    endcase
                    if ((phase == 2'd1 && !has_data) || phase == 2'd3) begin
                        phase       <= 2'd0;
                        adp_pending <= 1'b1;
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
            end else begin
                drop_burst <= 1'b0;
                if (phase != 2'd0) begin
                    phase     <= 2'd0;
                    o_adp_err <= 1'b1;
                end
            end
            if (adp_clr) adp_pending <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_rdi = 1'b0;
        grant_adp = 1'b0;
        adp_clr   = 1'b0;
        rdi_done  = 1'b0;
        case (state)
            IDLE: begin
                if (rdi_req_eff && adp_pending) begin
                    grant_rdi = last_adp;
                    grant_adp = !last_adp;
                end else begin
                    grant_rdi = rdi_req_eff;
                    grant_adp = adp_pending;
                end
                if (grant_rdi)      state_nxt = SEND_RDI;
                else if (grant_adp) state_nxt = SEND_HDR;
            end
            SEND_RDI: if (i_ser_done) begin
                state_nxt = IDLE;
                rdi_done  = 1'b1;
            end
            SEND_HDR: if (i_ser_done) begin
                state_nxt = has_data ? GAP : IDLE;
                adp_clr   = !has_data;
            end
            GAP: state_nxt = SEND_DAT;
            SEND_DAT: if (i_ser_done) begin
                state_nxt = IDLE;
                adp_clr   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            rdi_buf      <= 64'h0;
            last_adp     <= 1'b1;
            o_rdi_ack    <= 1'b0;
            o_lp_cfg_crd <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_rdi_ack    <= rdi_done;
            o_lp_cfg_crd <= adp_clr;
            if (grant_rdi) rdi_buf <= i_rdi_pkt;
            if (grant_rdi || grant_adp) last_adp <= grant_adp;
        end
    end

    // Word outputs decode straight from registered state so reset zeroes them at once.
    always_comb begin
        o_ser_valid = 1'b0;
        o_ser_data  = 64'h0;
        case (state)
            SEND_RDI: begin o_ser_valid = 1'b1; o_ser_data = rdi_buf; end
            SEND_HDR: begin o_ser_valid = 1'b1; o_ser_data = hdr_buf; end
            SEND_DAT: begin o_ser_valid = 1'b1; o_ser_data = dat_buf; end
            default: ;
        endcase
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed vector table plus hand-written corner sequences for sb_tx_arbiter.
module tb_sb_tx_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_rdi_req;
    logic [63:0] i_rdi_pkt;
    logic        o_rdi_ack;
    logic [31:0] i_lp_cfg;
    logic        i_lp_cfg_vld;
    logic        o_lp_cfg_crd;
    logic        o_adp_err;
    logic        o_ser_valid;
    logic [63:0] o_ser_data;
    logic        i_ser_done;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] P  = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] Q  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] H0 = 64'h0200_0001_0000_4012;
    localparam logic [63:0] H1 = 64'hCAFE_0000_0000_001B;
    localparam logic [63:0] D1 = 64'h3333_4444_1111_2222;

    sb_tx_arbiter #(.OPC_WITH_DATA(5'b11011)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rdi_req    (i_rdi_req),
        .i_rdi_pkt    (i_rdi_pkt),
        .o_rdi_ack    (o_rdi_ack),
        .i_lp_cfg     (i_lp_cfg),
        .i_lp_cfg_vld (i_lp_cfg_vld),
        .o_lp_cfg_crd (o_lp_cfg_crd),
        .o_adp_err    (o_adp_err),
        .o_ser_valid  (o_ser_valid),
        .o_ser_data   (o_ser_data),
        .i_ser_done   (i_ser_done),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic [63:0] pkt;
        logic        vld;
        logic [31:0] cfg;
        logic        done;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_ack;
        logic        e_crd;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, req, input logic [63:0] pkt,
                                input logic vld, input logic [31:0] cfg, input logic done,
                                input logic ev, input logic [63:0] ed,
                                input logic ea, ec, ee, eb);
        vec_t v;
        v.rst = rst; v.req = req; v.pkt = pkt; v.vld = vld; v.cfg = cfg; v.done = done;
        v.e_valid = ev; v.e_data = ed; v.e_ack = ea; v.e_crd = ec; v.e_err = ee; v.e_busy = eb;
        return v;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [63:0] ed,
                           input logic ea, ec, ee, eb);
        chk({nm, ".valid"}, {63'h0, o_ser_valid},  {63'h0, ev});
        chk({nm, ".data"},  o_ser_data,            ed);
        chk({nm, ".ack"},   {63'h0, o_rdi_ack},    {63'h0, ea});
        chk({nm, ".crd"},   {63'h0, o_lp_cfg_crd}, {63'h0, ec});
        chk({nm, ".err"},   {63'h0, o_adp_err},    {63'h0, ee});
        chk({nm, ".busy"},  {63'h0, o_busy},       {63'h0, eb});
    endtask

    task automatic phase(input logic [31:0] d);
        i_lp_cfg     = d;
        i_lp_cfg_vld = 1'b1;
        step();
    endtask

    task automatic load_with_data();
        phase(32'h0000_001B);
        phase(32'hCAFE_0000);
        phase(32'h1111_2222);
        phase(32'h3333_4444);
        i_lp_cfg_vld = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_rdi_req = 1'b0; i_rdi_pkt = 64'h0;
        i_lp_cfg = 32'h0; i_lp_cfg_vld = 1'b0; i_ser_done = 1'b0;

        // rst req pkt vld cfg done | valid data ack crd err busy
        tbl.push_back(mk(1,0,64'h0,0,32'h0,0,          0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,1,P,0,32'h0,0,              1,P,0,0,0,1));
        tbl.push_back(mk(0,1,Q,0,32'h0,0,              1,P,0,0,0,1));
        tbl.push_back(mk(0,1,Q,0,32'h0,1,              0,64'h0,1,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0000_4012,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0200_0001,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          1,H0,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,1,          0,64'h0,0,1,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0000_001B,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'hCAFE_0000,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h1111_2222,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h3333_4444,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          1,H1,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,1,          0,64'h0,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,1,          1,D1,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          1,D1,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,1,          0,64'h0,0,1,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          0,64'h0,0,0,0,0));
        // tie after reset: RDI first, adapter next, repeat tie goes to RDI
        tbl.push_back(mk(1,0,64'h0,0,32'h0,0,          0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0000_4012,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0200_0001,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,1,Q,0,32'h0,0,              1,Q,0,0,0,1));
        tbl.push_back(mk(0,1,Q,0,32'h0,1,              0,64'h0,1,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          1,H0,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,1,          0,64'h0,0,1,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0000_4012,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,0,64'h0,1,32'h0200_0001,0,  0,64'h0,0,0,0,0));
        tbl.push_back(mk(0,1,P,0,32'h0,0,              1,P,0,0,0,1));
        tbl.push_back(mk(0,1,P,0,32'h0,1,              0,64'h0,1,0,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          1,H0,0,0,0,1));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,1,          0,64'h0,0,1,0,0));
        tbl.push_back(mk(0,0,64'h0,0,32'h0,0,          0,64'h0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            i_rst = tbl[i].rst; i_rdi_req = tbl[i].req; i_rdi_pkt = tbl[i].pkt;
            i_lp_cfg_vld = tbl[i].vld; i_lp_cfg = tbl[i].cfg; i_ser_done = tbl[i].done;
            step();
            chk_out($sformatf("v%0d", i), tbl[i].e_valid, tbl[i].e_data,
                    tbl[i].e_ack, tbl[i].e_crd, tbl[i].e_err, tbl[i].e_busy);
        end
        i_ser_done = 1'b0; i_rdi_req = 1'b0; i_lp_cfg_vld = 1'b0;

        // RDI request arriving mid adapter packet waits for the data word
        load_with_data();
        step();                  chk_out("mid.hdr", 1, H1, 0, 0, 0, 1);
        i_rdi_req = 1'b1; i_rdi_pkt = P;
        step();                  chk_out("mid.hdr_hold", 1, H1, 0, 0, 0, 1);
        i_ser_done = 1'b1; step(); chk_out("mid.gap", 0, 64'h0, 0, 0, 0, 1);
        i_ser_done = 1'b0; step(); chk_out("mid.dat", 1, D1, 0, 0, 0, 1);
        i_ser_done = 1'b1; step(); chk_out("mid.dat_done", 0, 64'h0, 0, 1, 0, 0);
        i_ser_done = 1'b0; step(); chk_out("mid.rdi", 1, P, 0, 0, 0, 1);
        i_ser_done = 1'b1; step(); chk_out("mid.rdi_done", 0, 64'h0, 1, 0, 0, 0);
        i_ser_done = 1'b0; i_rdi_req = 1'b0;
        step();                  chk_out("mid.idle", 0, 64'h0, 0, 0, 0, 0);

        // vld drops after phase 2 of a with-data packet
        phase(32'h0000_001B);
        phase(32'hCAFE_0000);
        phase(32'h1111_2222);
        i_lp_cfg_vld = 1'b0;
        step();                  chk_out("trunc.err", 0, 64'h0, 0, 0, 1, 0);
        step();                  chk_out("trunc.quiet", 0, 64'h0, 0, 0, 0, 0);
        step();                  chk_out("trunc.none", 0, 64'h0, 0, 0, 0, 0);

        // new packet while one is pending: one error, pending word untouched
        phase(32'h0000_4012);
        phase(32'h0200_0001);
        phase(32'hDEAD_BEEF);    chk_out("ovr.err", 1, H0, 0, 0, 1, 1);
        phase(32'h1234_5678);    chk_out("ovr.once", 1, H0, 0, 0, 0, 1);
        i_lp_cfg_vld = 1'b0; i_ser_done = 1'b1;
        step();                  chk_out("ovr.done", 0, 64'h0, 0, 1, 0, 0);
        i_ser_done = 1'b0;
        step();                  chk_out("ovr.idle", 0, 64'h0, 0, 0, 0, 0);
        step();                  chk_out("ovr.no_ghost", 0, 64'h0, 0, 0, 0, 0);

        // reset while serializing the data word
        load_with_data();
        step();                  chk_out("rst.hdr", 1, H1, 0, 0, 0, 1);
        i_ser_done = 1'b1; step(); chk_out("rst.gap", 0, 64'h0, 0, 0, 0, 1);
        i_ser_done = 1'b0; step(); chk_out("rst.dat", 1, D1, 0, 0, 0, 1);
        i_rst = 1'b1;
        #1;                      chk_out("rst.async", 0, 64'h0, 0, 0, 0, 0);
        i_ser_done = 1'b1;
        step();                  chk_out("rst.held", 0, 64'h0, 0, 0, 0, 0);
        i_ser_done = 1'b0; i_rst = 1'b0;
        step();                  chk_out("rst.first", 0, 64'h0, 0, 0, 0, 0);
        phase(32'h0000_4012);
        phase(32'h0200_0001);
        i_lp_cfg_vld = 1'b0;
        step();                  chk_out("rst.fresh", 1, H0, 0, 0, 0, 1);
        i_ser_done = 1'b1; step(); chk_out("rst.fresh_done", 0, 64'h0, 0, 1, 0, 0);
        i_ser_done = 1'b0; step(); chk_out("rst.end", 0, 64'h0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
